// File: rtl/ring_counter_param.sv
// ---------------------------------------------------------------------------
// ring_counter_param
//
// Parametrised ring / Johnson (twisted-ring) counter used as a sequencer or
// strobe generator for downstream stage selects. Supports direction select,
// count enable, parallel load, one-step self-correction from illegal states
// and a registered wrap pulse on re-entry to the start state.
//
// Parameters:
//   WIDTH  number of flops in the ring (2..32)
//   INIT   ring-mode start state, must be one-hot
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   en        in   advance one state per clock when high
//   mode      in   0 = ring (one-hot rotate), 1 = Johnson (inverted feedback)
//   dir       in   0 = shift toward MSB, 1 = shift toward LSB
//   load      in   parallel load strobe
//   load_val  in   value captured on load (taken verbatim, even if illegal)
//   q         out  registered counter state
//   wrap      out  registered one-cycle pulse on legal re-entry to start state
//   illegal   out  combinational: q is not a legal state for current mode
// ---------------------------------------------------------------------------
module ring_counter_param #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] INIT  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             illegal
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  function automatic logic is_onehot(input logic [WIDTH-1:0] v);
    return (v != ZERO) && ((v & (v - ONE)) == ZERO);
  endfunction

  // Contiguous ones anchored at the LSB (0..01..1), including all-zeros and
  // all-ones: adding one carries through every set bit and leaves no overlap.
  function automatic logic is_thermo_lsb(input logic [WIDTH-1:0] v);
    return ((v & (v + ONE)) == ZERO);
  endfunction

  // Johnson legal set: LSB-anchored ones, or MSB-anchored ones (whose
  // complement is LSB-anchored).
  function automatic logic is_johnson(input logic [WIDTH-1:0] v);
    return is_thermo_lsb(v) || is_thermo_lsb(~v);
  endfunction

  logic             legal_s;
  logic [WIDTH-1:0] start_s;
  logic [WIDTH-1:0] step_s;
  logic [WIDTH-1:0] next_s;

  // Legality, start state and successor of the current state.
  always_comb begin
    legal_s = 1'b0;
    start_s = ZERO;
    step_s  = q;
    next_s  = q;

    if (mode) begin
      legal_s = is_johnson(q);
      start_s = ZERO;
    end else begin
      legal_s = is_onehot(q);
      start_s = INIT;
    end

    case ({mode, dir})
      2'b00:   step_s = {q[WIDTH-2:0], q[WIDTH-1]};
      2'b01:   step_s = {q[0], q[WIDTH-1:1]};
      2'b10:   step_s = {q[WIDTH-2:0], ~q[WIDTH-1]};
      2'b11:   step_s = {~q[0], q[WIDTH-1:1]};
      default: step_s = start_s;
    endcase

    // Illegal states collapse to the start state in a single enabled step.
    if (legal_s) begin
      next_s = step_s;
    end else begin
      next_s = start_s;
    end
  end

  // Illegal flag follows q and mode with no register in the path.
  always_comb begin
    illegal = ~legal_s;
  end

  // State and wrap registers: rst > load > en > hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= start_s;
      wrap <= 1'b0;
    end else if (load) begin
      q    <= load_val;
      wrap <= 1'b0;
    end else if (en) begin
      q    <= next_s;
      // A correction step also lands on the start state but is not a wrap.
      wrap <= legal_s && (step_s == start_s);
    end else begin
      q    <= q;
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ring_counter_param.sv
// ---------------------------------------------------------------------------
// tb_ring_counter_param
//
// Directed self-checking bench for ring_counter_param at WIDTH=4, INIT=0001.
// Inputs are driven 1 time unit after the rising edge and outputs sampled at
// the same point after the following edge; expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_ring_counter_param;

  logic       clk;
  logic       rst;
  logic       en;
  logic       mode;
  logic       dir;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] q;
  logic       wrap;
  logic       illegal;

  int checks;
  int errors;

  ring_counter_param #(
    .WIDTH (4),
    .INIT  (4'b0001)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .wrap     (wrap),
    .illegal  (illegal)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check all three outputs at once.
  task automatic chk_all(input string tag, input logic [3:0] eq, input logic ew, input logic ei);
    chk({tag, ".q"}, {28'd0, q}, {28'd0, eq});
    chk({tag, ".wrap"}, {31'd0, wrap}, {31'd0, ew});
    chk({tag, ".illegal"}, {31'd0, illegal}, {31'd0, ei});
  endtask

  // Advance one clock and move to the sampling point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] ring_seq [8];
  logic [3:0] jf_seq   [8];
  logic [3:0] jb_seq   [8];

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    en       = 1'b0;
    mode     = 1'b0;
    dir      = 1'b0;
    load     = 1'b0;
    load_val = 4'b0000;

    ring_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    jf_seq   = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    jb_seq   = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};

    // Ring reset and forward run: wraps after steps 4 and 8.
    tick();
    chk_all("ring_rst", 4'b0001, 1'b0, 1'b0);
    rst = 1'b0;
    en  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_all($sformatf("ring_fwd%0d", i), ring_seq[i], (i == 3) || (i == 7), 1'b0);
    end

    // Johnson forward: reset to 0000, wrap only on 8th step.
    mode = 1'b1;
    rst  = 1'b1;
    tick();
    chk_all("john_rst", 4'b0000, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_all($sformatf("john_fwd%0d", i), jf_seq[i], i == 7, 1'b0);
    end

    // Johnson backward.
    dir = 1'b1;
    rst = 1'b1;
    tick();
    chk_all("johnb_rst", 4'b0000, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_all($sformatf("john_bwd%0d", i), jb_seq[i], i == 7, 1'b0);
    end

    // Ring: load illegal 0110, correct to 0001 without wrap.
    mode = 1'b0;
    dir  = 1'b0;
    rst  = 1'b1;
    en   = 1'b0;
    tick();
    rst      = 1'b0;
    load     = 1'b1;
    load_val = 4'b0110;
    tick();
    chk_all("ring_ld_ill", 4'b0110, 1'b0, 1'b1);
    load = 1'b0;
    en   = 1'b1;
    tick();
    chk_all("ring_fix", 4'b0001, 1'b0, 1'b0);

    // Johnson at 0111, switch to ring: illegal rises without a clock.
    mode = 1'b1;
    rst  = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    chk_all("john_0111", 4'b0111, 1'b0, 1'b0);
    en   = 1'b0;
    mode = 1'b0;
    #1;
    chk("mode_sw_illegal", {31'd0, illegal}, 32'd1);
    en = 1'b1;
    tick();
    chk_all("mode_sw_fix", 4'b0001, 1'b0, 1'b0);

    // Johnson: load 0101 (illegal), correct to 0000 with no wrap.
    mode     = 1'b1;
    en       = 1'b0;
    load     = 1'b1;
    load_val = 4'b0101;
    tick();
    chk_all("john_ld_ill", 4'b0101, 1'b0, 1'b1);
    load = 1'b0;
    en   = 1'b1;
    tick();
    chk_all("john_fix", 4'b0000, 1'b0, 1'b0);

    // Priority: rst beats load/en, load beats en, then hold.
    mode = 1'b0;
    rst  = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk_all("pri_pre", 4'b0100, 1'b0, 1'b0);
    rst      = 1'b1;
    load     = 1'b1;
    load_val = 4'b1111;
    tick();
    chk_all("pri_rst", 4'b0001, 1'b0, 1'b0);
    rst      = 1'b0;
    load_val = 4'b1000;
    tick();
    chk_all("pri_load", 4'b1000, 1'b0, 1'b0);
    load = 1'b0;
    en   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("hold%0d", i), 4'b1000, 1'b0, 1'b0);
    end

    // Ring direction reversal from 0100.
    en = 1'b1;
    tick();
    chk_all("rev_a", 4'b0001, 1'b1, 1'b0);
    tick();
    tick();
    chk_all("rev_b", 4'b0100, 1'b0, 1'b0);
    dir = 1'b1;
    tick();
    chk_all("rev_c", 4'b0010, 1'b0, 1'b0);
    tick();
    chk_all("rev_d", 4'b0001, 1'b1, 1'b0);
    tick();
    chk_all("rev_e", 4'b1000, 1'b0, 1'b0);

    // Legality boundaries for both modes (loads only).
    en   = 1'b0;
    load = 1'b1;
    mode = 1'b1;
    load_val = 4'b1000;
    tick();
    chk("j_1000_legal", {31'd0, illegal}, 32'd0);
    load_val = 4'b0001;
    tick();
    chk("j_0001_legal", {31'd0, illegal}, 32'd0);
    load_val = 4'b0010;
    tick();
    chk("j_0010_illegal", {31'd0, illegal}, 32'd1);
    mode = 1'b0;
    load_val = 4'b0000;
    tick();
    chk("r_0000_illegal", {31'd0, illegal}, 32'd1);
    load_val = 4'b1111;
    tick();
    chk("r_1111_illegal", {31'd0, illegal}, 32'd1);

    // Johnson reversal mid-sequence, then hold clears wrap.
    mode     = 1'b1;
    dir      = 1'b0;
    load_val = 4'b0011;
    tick();
    load = 1'b0;
    en   = 1'b1;
    tick();
    chk_all("jrev_a", 4'b0111, 1'b0, 1'b0);
    dir = 1'b1;
    tick();
    chk_all("jrev_b", 4'b0011, 1'b0, 1'b0);
    tick();
    chk_all("jrev_c", 4'b0001, 1'b0, 1'b0);
    tick();
    chk_all("jrev_d", 4'b0000, 1'b1, 1'b0);
    en = 1'b0;
    tick();
    chk_all("jhold", 4'b0000, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
